// File: rtl/seq_gen_tx.sv
// Serial pattern generator: sends a PAT_W-bit pattern MSB first, repeated
// reps times with gap zero-bit spacing, then pulses done for one cycle.
module seq_gen_tx #(
   parameter int               PAT_W   = 6,
   parameter logic [PAT_W-1:0] DEF_PAT = 6'b101011
) (
   input  logic             clko,
   input  logic             reset,
   input  logic             start,
   input  logic             load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [3:0]       reps,
   input  logic [2:0]       gap,
   output logic             outp,
   output logic             frame,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state
);

   localparam int            CW   = $clog2(PAT_W);
   localparam logic [CW-1:0] LAST = CW'(PAT_W - 1);

   typedef enum logic [2:0] {
      IDLE = 3'b001,
      SEND = 3'b010,
      GAP  = 3'b011,
      DONE = 3'b100
   } state_t;

   state_t           state_r, state_s;
   logic [PAT_W-1:0] pat_reg, pat_s;
   logic [CW-1:0]    bit_r, bit_s, nxt_s;
   logic [3:0]       rep_r, rep_s;
   logic [2:0]       gap_r, gap_s, gcnt_r, gcnt_s;
   logic             outp_r, frame_r, busy_r, done_r;
   logic             outp_s, frame_s, busy_s, done_s;

   // Next-state and next-output decode; rep_r counts repetitions still owed
   // after the current one, bit_r is the index of the bit now on outp.
   always_comb begin
      state_s = IDLE;
      pat_s   = pat_reg;
      bit_s   = bit_r;
      nxt_s   = bit_r + {{(CW-1){1'b0}}, 1'b1};
      rep_s   = rep_r;
      gap_s   = gap_r;
      gcnt_s  = gcnt_r;
      outp_s  = 1'b0;
      frame_s = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (load) begin
               pat_s = pat_in;
            end else begin
               pat_s = pat_reg;
            end
            if (start) begin
               state_s = SEND;
               rep_s   = (reps == 4'd0) ? 4'd0 : reps - 4'd1;
               gap_s   = gap;
               bit_s   = {CW{1'b0}};
               outp_s  = load ? pat_in[PAT_W-1] : pat_reg[PAT_W-1];
               frame_s = 1'b1;
               busy_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            if (bit_r == LAST) begin
               bit_s = {CW{1'b0}};
               if (rep_r == 4'd0) begin
                  state_s = DONE;
                  done_s  = 1'b1;
               end else if (gap_r != 3'd0) begin
                  state_s = GAP;
                  gcnt_s  = gap_r;
                  rep_s   = rep_r - 4'd1;
                  busy_s  = 1'b1;
               end else begin
                  state_s = SEND;
                  rep_s   = rep_r - 4'd1;
                  outp_s  = pat_reg[PAT_W-1];
                  frame_s = 1'b1;
                  busy_s  = 1'b1;
               end
            end else begin
               state_s = SEND;
               bit_s   = nxt_s;
               outp_s  = pat_reg[LAST - nxt_s];
               frame_s = 1'b1;
               busy_s  = 1'b1;
            end
         end
         GAP: begin
            busy_s = 1'b1;
            if (gcnt_r <= 3'd1) begin
               state_s = SEND;
               gcnt_s  = 3'd0;
               bit_s   = {CW{1'b0}};
               outp_s  = pat_reg[PAT_W-1];
               frame_s = 1'b1;
            end else begin
               state_s = GAP;
               gcnt_s  = gcnt_r - 3'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
            if (load) begin
               pat_s = pat_in;
            end else begin
               pat_s = pat_reg;
            end
         end
         default: begin
            state_s = IDLE;
            bit_s   = {CW{1'b0}};
            rep_s   = 4'd0;
            gcnt_s  = 3'd0;
         end
      endcase
   end

   // State, counters, pattern and all outputs registered together.
   always_ff @(posedge clko or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         pat_reg <= DEF_PAT;
         bit_r   <= {CW{1'b0}};
         rep_r   <= 4'd0;
         gap_r   <= 3'd0;
         gcnt_r  <= 3'd0;
         outp_r  <= 1'b0;
         frame_r <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         pat_reg <= pat_s;
         bit_r   <= bit_s;
         rep_r   <= rep_s;
         gap_r   <= gap_s;
         gcnt_r  <= gcnt_s;
         outp_r  <= outp_s;
         frame_r <= frame_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign outp  = outp_r;
   assign frame = frame_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign state = state_r;

endmodule

// File: tb/tb_seq_gen_tx.sv
// Scoreboard bench for seq_gen_tx: expected per-cycle output tuples are
// queued at stimulus time and popped by a negedge monitor.
module tb_seq_gen_tx;

   localparam logic [5:0] DEF = 6'b101011;

   logic       clko = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       load = 1'b0;
   logic [5:0] pat_in = 6'd0;
   logic [3:0] reps = 4'd0;
   logic [2:0] gap = 3'd0;
   logic       outp, frame, busy, done;
   logic [2:0] state;

   int         tests = 0;
   int         fails = 0;
   logic [6:0] exp_q[$];
   logic [5:0] pat_model;
   bit         mon_en = 1'b0;
   logic [6:0] obs_m, exp_m;

   seq_gen_tx #(.PAT_W(6), .DEF_PAT(6'b101011)) dut (
      .clko(clko), .reset(reset), .start(start), .load(load),
      .pat_in(pat_in), .reps(reps), .gap(gap),
      .outp(outp), .frame(frame), .busy(busy), .done(done), .state(state)
   );

   always #5 clko = ~clko;

   // Expected tuple {outp,frame,busy,done,state} for every cycle of a frame
   function automatic void push_frame(input logic [5:0] p, input int rr, input int g);
      for (int k = 0; k < rr; k++) begin
         for (int b = 5; b >= 0; b--) exp_q.push_back({p[b], 1'b1, 1'b1, 1'b0, 3'b010});
         if (k < rr - 1)
            for (int j = 0; j < g; j++) exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 3'b011});
      end
      exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 3'b100});
   endfunction

   task automatic load_only(input logic [5:0] p);
      load = 1'b1; pat_in = p; pat_model = p;
      @(posedge clko); #1;
      load = 1'b0;
   endtask

   // Issue one start; optionally poke start/load mid-frame or load during DONE
   task automatic run_frame(input logic ld, input logic [5:0] p, input logic [3:0] r,
                            input logic [2:0] g, input bit poke, input bit dload);
      int rr, len, pc;
      logic [5:0] tx, x;
      rr  = (r == 4'd0) ? 1 : int'(r);
      len = rr * 6 + (rr - 1) * int'(g);
      tx  = ld ? p : pat_model;
      if (ld) pat_model = p;
      push_frame(tx, rr, int'(g));
      start = 1'b1; load = ld; pat_in = p; reps = r; gap = g;
      pc = poke ? int'($urandom_range(0, len - 1)) : -1;
      for (int c = 0; c <= len; c++) begin
         @(posedge clko); #1;
         start = 1'b0; load = 1'b0;
         pat_in = 6'($urandom); reps = 4'($urandom); gap = 3'($urandom);
         if (c == pc) begin
            start = 1'b1; load = 1'b1; pat_in = 6'b000111;
         end
         if (c == len && dload) begin
            x = 6'($urandom);
            start = 1'b1; load = 1'b1; pat_in = x; pat_model = x;
         end
      end
      @(posedge clko); #1;
      start = 1'b0; load = 1'b0;
   endtask

   // Monitor: pops on active output cycles, checks quiet IDLE otherwise
   always @(negedge clko) begin
      if (mon_en) begin
         obs_m = {outp, frame, busy, done, state};
         if (busy || frame || done) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_out got=%b want=none", obs_m);
            end else begin
               exp_m = exp_q.pop_front();
               if (obs_m !== exp_m) begin
                  fails++;
                  $display("FAIL frame_cycle t=%0t got=%b want=%b", $time, obs_m, exp_m);
               end
            end
         end else begin
            tests++;
            if (obs_m !== 7'b0000001) begin
               fails++;
               $display("FAIL idle_out t=%0t got=%b want=%b", $time, obs_m, 7'b0000001);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      pat_model = DEF;
      #1 reset = 1'b1;
      #1;
      tests++;
      if ({outp, frame, busy, done, state} !== 7'b0000001) begin
         fails++;
         $display("FAIL reset_state got=%b want=%b", {outp, frame, busy, done, state}, 7'b0000001);
      end
      mon_en = 1'b1;
      @(posedge clko); #2 reset = 1'b0;

      run_frame(1'b0, 6'd0, 4'd1, 3'd0, 1'b0, 1'b0);
      run_frame(1'b0, 6'd0, 4'd3, 3'd0, 1'b0, 1'b0);
      run_frame(1'b0, 6'd0, 4'd1, 3'd1, 1'b1, 1'b0);
      run_frame(1'b0, 6'd0, 4'd2, 3'd3, 1'b1, 1'b0);
      load_only(6'b110010);
      run_frame(1'b0, 6'd0, 4'd2, 3'd2, 1'b0, 1'b0);

      // abort during the third bit
      start = 1'b1; load = 1'b0; reps = 4'd1; gap = 3'd0;
      push_frame(pat_model, 1, 0);
      @(posedge clko); #1 start = 1'b0;
      @(posedge clko);
      @(posedge clko); #3 reset = 1'b1;
      exp_q.delete();
      pat_model = DEF;
      #1;
      tests++;
      if ({outp, frame, busy, done, state} !== 7'b0000001) begin
         fails++;
         $display("FAIL reset_abort got=%b want=%b", {outp, frame, busy, done, state}, 7'b0000001);
      end
      @(posedge clko); #2 reset = 1'b0;
      run_frame(1'b0, 6'd0, 4'd1, 3'd0, 1'b0, 1'b0);

      run_frame(1'b1, 6'b100001, 4'd0, 3'd5, 1'b0, 1'b0);
      run_frame(1'b0, 6'd0, 4'd2, 3'd1, 1'b0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) load_only(6'($urandom));
         run_frame(1'($urandom), 6'($urandom), 4'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom));
      end

      repeat (4) @(posedge clko);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
